// File: rtl/song_pkg.sv
// Shared definitions for the song order-list sequencer.
//   - state_e     : sequencer FSM states
//   - field bit positions of an order ROM entry
//   - NOTE_W      : width of the note-sequencer address / length fields
package song_pkg;

  localparam int NOTE_W   = 5;
  localparam int END_BIT  = 15;
  localparam int LEN_MSB  = 9;
  localparam int LEN_LSB  = 5;
  localparam int ADDR_MSB = 4;
  localparam int ADDR_LSB = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_ISSUE  = 3'd4,
    S_PLAY   = 3'd5
  } state_e;

endpackage

// File: rtl/song_order_decode.sv
// Combinational split of one order ROM entry.
// Ports:
//   data_i   [15:0]        raw order ROM word
//   end_o                  END flag (entry is a loop/terminator marker)
//   len_o    [NOTE_W-1:0]  pattern length (0 means 32)
//   addr_o   [NOTE_W-1:0]  pattern start address
//   target_o [ORDER_AW-1:0] loop target index (meaningful only for END)
module song_order_decode
  import song_pkg::*;
#(
  parameter int ORDER_AW = 4
) (
  input  logic [15:0]         data_i,
  output logic                end_o,
  output logic [NOTE_W-1:0]   len_o,
  output logic [NOTE_W-1:0]   addr_o,
  output logic [ORDER_AW-1:0] target_o
);

  assign end_o    = data_i[END_BIT];
  assign len_o    = data_i[LEN_MSB:LEN_LSB];
  assign addr_o   = data_i[ADDR_MSB:ADDR_LSB];
  assign target_o = data_i[ORDER_AW-1:0];

  // Bits 14:10 carry no meaning in a normal entry.
  logic unused_bits;
  assign unused_bits = ^data_i[14:10];

endmodule

// File: rtl/song_sequencer.sv
// Order-list sequencer driving the pattern-load side of note_sequencer.
// Walks a synchronous order ROM; for each pattern entry it pulses a load
// of (addr, len) and then counts shared note strobes until the pattern is
// exhausted, then fetches the next entry.
//
// Build option: SONG_SEQUENCER_LOOP_EN
//   defined   - an END entry jumps to its target index (song loops forever)
//   undefined - an END entry returns to IDLE
//
// Ports:
//   i_clk, i_rst           clock, async active-high reset
//   i_start, i_stop        playback control pulses (stop wins)
//   i_note_stb             note tick shared with note_sequencer
//   o_order_addr           order ROM address
//   i_order_data           order ROM data (1 cycle latency)
//   o_new_addr/len/valid   pattern load to note_sequencer
//   o_playing              high whenever not IDLE
//   o_error                sticky END-to-END error
//
// state  | meaning
// IDLE   | stopped, waiting for i_start
// FETCH  | order ROM address presented
// WAIT   | ROM read latency
// DECODE | entry inspected: load, loop/end, or error
// ISSUE  | one-cycle load pulse to note_sequencer
// PLAY   | counting note strobes through the pattern
module song_sequencer
  import song_pkg::*;
#(
  parameter int ORDER_AW = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic                i_note_stb,
  output logic [ORDER_AW-1:0] o_order_addr,
  input  logic [15:0]         i_order_data,
  output logic [NOTE_W-1:0]   o_new_addr,
  output logic [NOTE_W-1:0]   o_new_pattern_len,
  output logic                o_new_addr_valid,
  output logic                o_playing,
  output logic                o_error
);

  state_e              state_q, state_d;
  logic [ORDER_AW-1:0] index_q, index_d;
  logic [NOTE_W-1:0]   cnt_q, cnt_d;
  logic [NOTE_W-1:0]   addr_q, addr_d;
  logic [NOTE_W-1:0]   len_q, len_d;
  logic                seen_q, seen_d;
  logic                err_q, err_d;

  logic                dec_end;
  logic [NOTE_W-1:0]   dec_len;
  logic [NOTE_W-1:0]   dec_addr;
  logic [ORDER_AW-1:0] dec_target;
  logic [NOTE_W-1:0]   last_note;

  song_order_decode #(.ORDER_AW(ORDER_AW)) u_decode (
    .data_i   (i_order_data),
    .end_o    (dec_end),
    .len_o    (dec_len),
    .addr_o   (dec_addr),
    .target_o (dec_target)
  );

  // Wraps to 31 for len 0, so a zero length plays 32 notes.
  assign last_note = len_q - NOTE_W'(1);

`ifndef SONG_SEQUENCER_LOOP_EN
  logic unused_target;
  assign unused_target = ^dec_target;
`endif

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = len_q;
    seen_d  = seen_q;
    err_d   = err_q;

    if (i_stop) begin
      state_d = S_IDLE;
      index_d = '0;
      cnt_d   = '0;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_d = S_FETCH;
            index_d = '0;
            err_d   = 1'b0;
          end
        end
        S_FETCH:  state_d = S_WAIT;
        S_WAIT:   state_d = S_DECODE;
        S_DECODE: begin
          if (!dec_end) begin
            addr_d  = dec_addr;
            len_d   = dec_len;
            seen_d  = 1'b0;
            state_d = S_ISSUE;
          end else if (seen_q) begin
            // Two END entries with no pattern between: the song is empty.
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            seen_d  = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
            index_d = dec_target;
            state_d = S_FETCH;
`else
            state_d = S_IDLE;
`endif
          end
        end
        S_ISSUE: begin
          cnt_d   = '0;
          state_d = S_PLAY;
        end
        S_PLAY: begin
          if (i_note_stb) begin
            cnt_d = cnt_q + NOTE_W'(1);
            if (cnt_q == last_note) begin
              index_d = index_q + ORDER_AW'(1);
              state_d = S_FETCH;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      index_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      seen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
    end
  end

  assign o_order_addr      = index_q;
  assign o_new_addr        = addr_q;
  assign o_new_pattern_len = len_q;
  assign o_new_addr_valid  = (state_q == S_ISSUE);
  assign o_playing         = (state_q != S_IDLE);
  assign o_error           = err_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: a song-level model predicts each
// pattern load (cycle, addr, len) from the ROM contents; a monitor pops and
// compares whenever the DUT pulses o_new_addr_valid.
module tb_song_sequencer;

  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start, i_stop, i_note_stb;
  logic [AW-1:0] o_order_addr;
  logic [15:0]   i_order_data;
  logic [4:0]    o_new_addr, o_new_pattern_len;
  logic          o_new_addr_valid, o_playing, o_error;

  song_sequencer #(.ORDER_AW(AW)) dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_start           (i_start),
    .i_stop            (i_stop),
    .i_note_stb        (i_note_stb),
    .o_order_addr      (o_order_addr),
    .i_order_data      (i_order_data),
    .o_new_addr        (o_new_addr),
    .o_new_pattern_len (o_new_pattern_len),
    .o_new_addr_valid  (o_new_addr_valid),
    .o_playing         (o_playing),
    .o_error           (o_error)
  );

  always #5 i_clk = ~i_clk;

  // Synchronous order ROM.
  logic [15:0] rom [16];
  logic [15:0] rom_q;
  always @(posedge i_clk) rom_q <= rom[o_order_addr];
  assign i_order_data = rom_q;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct { int cyc; int addr; int len; } exp_t;
  exp_t exp_q[$];

  // Song-level model state.
  int m_idx, m_len, m_load_cyc, m_idle_at;
  bit m_seen, m_err, m_active;

  // From a fetch kicked off by an event at cycle base, walk the order list
  // until a pattern is found (push its load) or playback ends.
  task automatic resolve(input int base);
    int extra = 0;
    logic [15:0] e;
    for (int guard = 0; guard < 40; guard++) begin
      e = rom[m_idx];
      if (!e[15]) begin
        m_seen = 1'b0;
        m_len  = (e[9:5] == 0) ? 32 : int'(e[9:5]);
        m_load_cyc = base + 4 + extra;
        exp_q.push_back('{cyc: m_load_cyc, addr: int'(e[4:0]), len: int'(e[9:5])});
        m_active = 1'b1;
        return;
      end
      if (m_seen) begin
        m_err = 1'b1; m_active = 1'b0; m_idle_at = base + 4 + extra;
        return;
      end
      m_seen = 1'b1;
`ifdef SONG_SEQUENCER_LOOP_EN
      m_idx = int'(e[AW-1:0]);
      extra += 3;
`else
      m_active = 1'b0; m_idle_at = base + 4 + extra;
      return;
`endif
    end
  endtask

  // Monitor.
  bit prev_valid = 1'b0;
  always @(negedge i_clk) begin
    if (i_rst) prev_valid = 1'b0;
    else begin
      if (o_new_addr_valid) begin
        chk("valid_not_back_to_back", int'(prev_valid), 0);
        if (exp_q.size() == 0) chk("unexpected_load", 1, 0);
        else begin
          exp_t x;
          x = exp_q.pop_front();
          chk("load_cycle", cyc, x.cyc);
          chk("load_addr", int'(o_new_addr), x.addr);
          chk("load_len", int'(o_new_pattern_len), x.len);
        end
      end
      prev_valid = o_new_addr_valid;
    end
  end

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic do_start(input bit stb_early);
    int p;
    p = cyc;
    i_start = 1'b1;
    m_idx = 0; m_err = 1'b0;
    resolve(p);
    step();
    i_start = 1'b0;
    chk("error_clear_on_start", int'(o_error), 0);
    if (stb_early) begin
      i_note_stb = 1'b1;  // sampled in FETCH and WAIT
      step(); step();
      i_note_stb = 1'b0;
    end
  endtask

  task automatic do_stop();
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    m_active = 1'b0; m_seen = 1'b0; m_idx = 0;
    chk("stop_idle", int'(o_playing), 0);
  endtask

  task automatic play(input int max_pat);
    int npat = 0;
    int last = -100;
    int tgt;
    while (m_active && npat < max_pat) begin
      while (cyc < m_load_cyc + 1) step();
      chk("playing_in_pattern", int'(o_playing), 1);
      for (int k = 1; k <= m_len; k++) begin
        tgt = last + int'($urandom_range(8, 10));
        if (tgt < m_load_cyc + 1) tgt = m_load_cyc + 1;
        while (cyc < tgt) step();
        if (k == m_len) chk("playing_before_last", int'(o_playing), 1);
        i_note_stb = 1'b1;
        last = cyc;
        step();
        i_note_stb = 1'b0;
      end
      npat++;
      m_idx = (m_idx + 1) % 16;
      resolve(last);
    end
    if (m_active) begin
      while (cyc < m_load_cyc + 1) step();
      do_stop();
    end else begin
      while (cyc < m_idle_at) step();
      chk("song_end_idle", int'(o_playing), 0);
      chk("song_end_error", int'(o_error), int'(m_err));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
    chk("queue_drained", exp_q.size(), 0);
  endtask

  function automatic logic [15:0] norm(input int addr, input int len);
    logic [15:0] e;
    e = 16'($urandom);
    e[15] = 1'b0;
    e[9:5] = 5'(len);
    e[4:0] = 5'(addr);
    return e;
  endfunction

  function automatic logic [15:0] endw(input int tgt);
    logic [15:0] e;
    e = 16'($urandom);
    e[15] = 1'b1;
    e[AW-1:0] = AW'(tgt);
    return e;
  endfunction

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_stop = 1'b0; i_note_stb = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = norm(i, 1);
    #2;
    chk("rst_order_addr", int'(o_order_addr), 0);
    chk("rst_new_addr", int'(o_new_addr), 0);
    chk("rst_new_len", int'(o_new_pattern_len), 0);
    chk("rst_valid", int'(o_new_addr_valid), 0);
    chk("rst_playing", int'(o_playing), 0);
    chk("rst_error", int'(o_error), 0);
    m_idx = 0; m_seen = 0; m_err = 0; m_active = 0;
    step(); step();
    i_rst = 1'b0;
    step();

    // Basic song: {3,2}, {10,1}, END->0.
    rom[0] = norm(3, 2); rom[1] = norm(10, 1); rom[2] = endw(0);
    do_start(1'b0);
    play(6);
    drain();

    // Strobes during FETCH/WAIT must not be counted.
    do_start(1'b1);
    play(3);
    drain();

    // len 0 plays 32 notes.
    rom[0] = norm(5, 0); rom[1] = norm(7, 3); rom[2] = endw(1);
    do_start(1'b0);
    play(4);
    drain();

    // Stop in WAIT.
    i_start = 1'b1; step(); i_start = 1'b0;   // now FETCH
    step();                                    // now WAIT
    i_stop = 1'b1; step(); i_stop = 1'b0;
    m_seen = 1'b0; m_idx = 0;
    chk("stop_in_wait", int'(o_playing), 0);
    repeat (10) step();

    // Start and stop together.
    i_start = 1'b1; i_stop = 1'b1; step(); i_start = 1'b0; i_stop = 1'b0;
    chk("start_stop_same", int'(o_playing), 0);
    repeat (10) step();

    // END at index 0: empty song, error detection.
    rom[0] = endw(0);
    do_start(1'b0); play(2); drain();
    do_start(1'b0); play(2); drain();
    chk("error_after_end_end", int'(o_error), int'(m_err));
    rom[0] = norm(9, 1);
    do_start(1'b0);
    chk("error_cleared", int'(o_error), 0);
    play(2);
    drain();

    // Index wrap across all 16 entries.
    for (int i = 0; i < 16; i++) rom[i] = norm($urandom_range(0, 31), 1);
    do_start(1'b0);
    play(18);
    drain();

    // Random songs.
    for (int t = 0; t < 6; t++) begin
      int k;
      k = $urandom_range(1, 4);
      for (int i = 0; i < 16; i++)
        rom[i] = norm($urandom_range(0, 31),
                      ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3));
      rom[k] = endw($urandom_range(0, k - 1));
      do_start(1'b0);
      play(5);
      drain();
    end

    // Async reset between edges mid-PLAY.
    rom[0] = norm(12, 4); rom[1] = endw(0);
    do_start(1'b0);
    while (cyc < m_load_cyc + 3) step();
    #2 i_rst = 1'b1;
    #1;
    chk("arst_order_addr", int'(o_order_addr), 0);
    chk("arst_new_addr", int'(o_new_addr), 0);
    chk("arst_new_len", int'(o_new_pattern_len), 0);
    chk("arst_valid", int'(o_new_addr_valid), 0);
    chk("arst_playing", int'(o_playing), 0);
    chk("arst_error", int'(o_error), 0);
    exp_q.delete();
    m_idx = 0; m_seen = 0; m_err = 0; m_active = 0;
    step();
    #2 i_rst = 1'b0;
    step(); step();
    chk("idle_after_reset", int'(o_playing), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Order-list sequencer that drives the pattern-load side of `note_sequencer`. It walks a synchronous order ROM of pattern entries, each giving a start address and a length. For each entry it issues a one-cycle `o_new_addr_valid` load to the note sequencer, then counts note strobes until the pattern is exhausted and fetches the next entry. It sits between the song-control logic (start/stop) and `note_sequencer`, sharing the note strobe.

## Interface
- `ORDER_AW`, default 4: order ROM address width; up to 2^ORDER_AW entries.

Ports:
- `i_clk`  in  1  system clock, all logic on rising edge.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `i_start`  in  1  pulse; begin playback at order index 0; ignored unless IDLE.
- `i_stop`  in  1  pulse; abort to IDLE; wins over `i_start` in the same cycle.
- `i_note_stb`  in  1  note tick, same strobe fed to `note_sequencer` `i_note_stb_1`.
- `o_order_addr`  out  ORDER_AW  order ROM address.
- `i_order_data`  in  16  order ROM data, valid 1 cycle after address (sync ROM).
- `o_new_addr`  out  5  pattern start address to `note_sequencer`.
- `o_new_pattern_len`  out  5  pattern length; 0 means 32.
- `o_new_addr_valid`  out  1  one-cycle load pulse.
- `o_playing`  out  1  high in any state except IDLE.
- `o_error`  out  1  sticky; cleared by `i_start` or reset.

## Operation
Order entry format:
- bit 15: END flag.
- END = 0: bits [9:5] hold len, bits [4:0] hold addr; bits [14:10] are ignored.
- END = 1: bits [ORDER_AW-1:0] hold the loop target index.

States:
- IDLE → FETCH on `i_start`. Index ← 0, `o_error` ← 0.
- FETCH: drive `o_order_addr` = index → WAIT.
- WAIT: ROM latency → DECODE.
- DECODE:
  - Normal entry: latch addr/len → ISSUE; clear the end-seen flag.
  - END entry with the end-seen flag clear: handled per Configuration; set end-seen.
  - END entry with the end-seen flag set (END reached END with no pattern between): `o_error` ← 1 → IDLE.
- ISSUE: `o_new_addr_valid` = 1 for this cycle only; note counter ← 0 → PLAY.
- PLAY: each `i_note_stb` increments the 5-bit note counter.
  - On a strobe when counter == len−1 (mod 32): index ← index+1 (wraps at 2^ORDER_AW) → FETCH.
  - len 0 therefore plays 32 notes.
- `i_note_stb` outside PLAY is ignored and not counted.
- `i_stop` in any state → IDLE on the next edge. Counter, index and the end-seen flag are cleared; `o_error` is held.

Reset values:
- All outputs 0: `o_order_addr`, `o_new_addr`, `o_new_pattern_len`, `o_new_addr_valid`, `o_playing`, `o_error`.
- State IDLE, index 0, counter 0, end-seen 0.

## Timing
- `i_start` at cycle N → FETCH at N+1, WAIT at N+2, DECODE at N+3, `o_new_addr_valid` high at N+4.
- Final note strobe of a pattern at cycle M → next `o_new_addr_valid` at M+4. An intervening END entry (loop taken) adds 3 cycles → M+7.
- `o_new_addr`/`o_new_pattern_len` are registered. They are updated in DECODE and held stable until the next DECODE of a normal entry.
- System requirement: note strobes are at least 8 cycles apart, so the next load always lands before the next strobe. The block does not check this.
- `o_new_addr_valid` never asserts on two consecutive cycles.

## Configuration
- `SONG_SEQUENCER_LOOP_EN` defined: END entry sets index ← target → FETCH (song loops forever).
- Undefined: END entry → IDLE, `o_playing` falls; the target field is ignored. The error check is still present: an END entry reached with the end-seen flag set still sets `o_error`.

## Structure
- Shared package `song_pkg`:
  - state enum (IDLE, FETCH, WAIT, DECODE, ISSUE, PLAY);
  - field constants: END bit 15, LEN_MSB/LSB 9/5, ADDR_MSB/LSB 4/0;
  - note-field width 5.
- One natural sub-module: `song_order_decode`, a combinational split of `i_order_data` into end/len/addr/target.
- Order ROM: existing `rom_sync`, instantiated outside this block.

## Test plan
- Start with ROM[0]={addr 3, len 2}, ROM[1]={addr 10, len 1}, ROM[2]=END:
  - valid at N+4 with addr 3 / len 2;
  - after the 2nd strobe, valid +4 cycles with addr 10 / len 1.
- Loop: `SONG_SEQUENCER_LOOP_EN` defined, ROM[2]=END target 0 → after ROM[1]'s strobe, valid +7 cycles with addr 3 again. Undefined → `o_playing`=0 and no further valid.
- len 0 entry: exactly 32 strobes counted before the next fetch; 31 strobes leave the FSM in PLAY.
- ROM[0]=END target 0 (loop build) → `o_error`=1, IDLE. A following `i_start` clears `o_error`.
- `i_stop` in WAIT and `i_start`+`i_stop` together → IDLE next cycle, no valid pulse. Strobes in FETCH/WAIT are not counted.
- Async `i_rst` asserted mid-PLAY between clock edges → all outputs 0 immediately, IDLE after release.
